// File: rtl/mac_column_sched.sv
// Column scheduler for a bit-serial MAC: walks the masked weight bit-columns of one tile from MSB
// down and pipelines each descriptor into the MAC. Define MAC_SCHED_PERF_EN for the stall counter.
module mac_column_sched #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned VEC_LENGTH    = 16,
    parameter int unsigned MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [7:0]                              cfg_col_mask,
    input  logic                                    desc_valid,
    output logic                                    desc_ready,
    input  logic [(VEC_LENGTH/2)*MUX_SEL_WIDTH-1:0] desc_act_sel,
    input  logic [MUX_SEL_WIDTH-1:0]                desc_hamming_sel,
    input  logic                                    desc_hamming_sign,
    input  logic [2:0]                              desc_mul_const,
    input  logic                                    desc_shift_mul,
    input  logic                                    desc_skip_zero,
    output logic [(VEC_LENGTH/2)*MUX_SEL_WIDTH-1:0] act_sel,
    output logic [MUX_SEL_WIDTH-1:0]                hamming_sel,
    output logic                                    hamming_sign,
    output logic [2:0]                              mul_const,
    output logic                                    is_shift_mul,
    output logic                                    is_skip_zero,
    output logic                                    is_msb,
    output logic [2:0]                              column_idx,
    output logic                                    mac_en,
    output logic                                    mac_clr,
    output logic                                    busy,
    output logic                                    done,
    output logic [15:0]                             perf_stall_cnt
);

    localparam int unsigned LANES = VEC_LENGTH / 2;
    localparam int unsigned ACT_W = LANES * MUX_SEL_WIDTH;
    // Select index VEC_LENGTH routes a zero into the MAC.
    localparam logic [MUX_SEL_WIDTH-1:0] ZERO_SEL   = MUX_SEL_WIDTH'(VEC_LENGTH);
    localparam logic [ACT_W-1:0]         BUBBLE_ACT = {LANES{ZERO_SEL}};

    typedef enum logic [2:0] {StIdle, StPrime, StClear, StRun, StDrain, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [2:0] col_q, col_d;
    logic [1:0] drain_q, drain_d;
    logic [7:0] rem;
    logic       ready_q;
    logic       fire;

    logic [MUX_SEL_WIDTH-1:0] s1_hsel;
    logic                     s1_hsign;
    logic [2:0]               s1_mulc;
    logic                     s1_shift;
    logic                     s1_skip;
    logic [2:0]               s1_col;
    logic                     s1_msb;

    // Activation width only matters inside the MAC itself.
    logic unused_data_width;
    assign unused_data_width = (DATA_WIDTH != 0);

    function automatic logic [2:0] top_col(input logic [7:0] m);
        top_col = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) top_col = 3'(i);
        end
    endfunction

    // Gating with reset keeps a descriptor from being consumed during the reset cycle.
    assign desc_ready = ready_q & ~reset;
    assign fire       = desc_valid & desc_ready;
    assign mac_en     = busy;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        col_d   = col_q;
        drain_d = 2'd0;
        rem     = mask_q & ~(8'd1 << col_q);
        case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d  = cfg_col_mask;
                    col_d   = top_col(cfg_col_mask);
                    state_d = StPrime;
                end
            end
            StPrime: state_d = StClear;
            StClear: state_d = (mask_q == 8'd0) ? StDrain : StRun;
            StRun: begin
                if (fire) begin
                    mask_d = rem;
                    col_d  = top_col(rem);
                    if (rem == 8'd0) state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mask_q  <= 8'd0;
            col_q   <= 3'd0;
            drain_q <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready_q <= 1'b0;
            mac_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            busy    <= state_d inside {StPrime, StClear, StRun, StDrain};
            done    <= (state_d == StDone);
            ready_q <= (state_d == StRun);
            mac_clr <= (state_d == StClear);
        end
    end

    // Two-stage issue: act selects lead the per-column PE fields by one cycle.
    always_ff @(posedge clk) begin
        if (fire) begin
            act_sel  <= desc_act_sel;
            s1_hsel  <= desc_hamming_sel;
            s1_hsign <= desc_hamming_sign;
            s1_mulc  <= desc_mul_const;
            s1_shift <= desc_shift_mul;
            s1_skip  <= desc_skip_zero;
            s1_col   <= col_q;
            s1_msb   <= (col_q == 3'd7);
        end else begin
            act_sel  <= BUBBLE_ACT;
            s1_hsel  <= ZERO_SEL;
            s1_hsign <= 1'b0;
            s1_mulc  <= 3'd0;
            s1_shift <= 1'b0;
            s1_skip  <= 1'b1;
            s1_col   <= 3'd0;
            s1_msb   <= 1'b0;
        end
        if (reset) begin
            hamming_sel  <= ZERO_SEL;
            hamming_sign <= 1'b0;
            mul_const    <= 3'd0;
            is_shift_mul <= 1'b0;
            is_skip_zero <= 1'b1;
            column_idx   <= 3'd0;
            is_msb       <= 1'b0;
        end else begin
            hamming_sel  <= s1_hsel;
            hamming_sign <= s1_hsign;
            mul_const    <= s1_mulc;
            is_shift_mul <= s1_shift;
            is_skip_zero <= s1_skip;
            column_idx   <= s1_col;
            is_msb       <= s1_msb;
        end
    end

`ifdef MAC_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (state_q == StIdle && start) begin
            stall_q <= 16'd0;
        end else if (state_q == StRun && !fire && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
`else
    assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mac_column_sched.sv
// Scoreboard bench for mac_column_sched: a driver pushes expected issue stages per handshake and a
// negedge monitor pops and compares them, alongside a small behavioural MAC for the tile result.
module tb_mac_column_sched;
    localparam int unsigned VL    = 16;
    localparam int unsigned MSW   = $clog2(VL) + 1;
    localparam int unsigned LANES = VL / 2;
    localparam int unsigned AW    = LANES * MSW;
    localparam int unsigned FW    = MSW + 10;
    localparam logic [MSW-1:0] ZS = MSW'(VL);

    typedef struct {
        logic [AW-1:0] act;
        logic [FW-1:0] fld;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, desc_valid = 1'b0;
    logic [7:0] cfg_col_mask = 8'd0;
    logic desc_ready;
    logic [AW-1:0] desc_act_sel = '0, act_sel;
    logic [MSW-1:0] desc_hamming_sel = '0, hamming_sel;
    logic desc_hamming_sign = 1'b0, desc_shift_mul = 1'b0, desc_skip_zero = 1'b0;
    logic [2:0] desc_mul_const = 3'd0, mul_const, column_idx;
    logic hamming_sign, is_shift_mul, is_skip_zero, is_msb, mac_en, mac_clr, busy, done;
    logic [15:0] perf_stall_cnt;

    mac_column_sched dut (
        .clk(clk), .reset(reset), .start(start), .cfg_col_mask(cfg_col_mask),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_act_sel(desc_act_sel),
        .desc_hamming_sel(desc_hamming_sel), .desc_hamming_sign(desc_hamming_sign),
        .desc_mul_const(desc_mul_const), .desc_shift_mul(desc_shift_mul),
        .desc_skip_zero(desc_skip_zero), .act_sel(act_sel), .hamming_sel(hamming_sel),
        .hamming_sign(hamming_sign), .mul_const(mul_const), .is_shift_mul(is_shift_mul),
        .is_skip_zero(is_skip_zero), .is_msb(is_msb), .column_idx(column_idx),
        .mac_en(mac_en), .mac_clr(mac_clr), .busy(busy), .done(done),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    exp_t exp_q[$];
    exp_t bub_e;
    int done_cnt = 0, clr_cnt = 0, rdy_cnt = 0, done_cyc = 0, done_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lane_sum(input logic [AW-1:0] a);
        int s = 0;
        for (int j = 0; j < LANES; j++) begin
            int sel = int'(a[j*MSW +: MSW]);
            if (sel < VL) s += sel * 3 + 1;
        end
        return s;
    endfunction

    function automatic int weigh(input int p, input int col, input logic msb);
        return msb ? -(p <<< col) : (p <<< col);
    endfunction

    function automatic exp_t mk_desc(input int k, input int col);
        exp_t e;
        for (int j = 0; j < LANES; j++) e.act[j*MSW +: MSW] = MSW'((k * 5 + j * 3 + 1) % VL);
        e.fld = {MSW'(k % VL), 1'(k & 1), 3'(k % 8), 1'((k >> 1) & 1), 1'((k >> 2) & 1),
                 3'(col), 1'(col == 7)};
        return e;
    endfunction

    // Behavioural bit-serial MAC driven by the scheduler outputs.
    int p_q = 0, acc_q = 0;
    always @(posedge clk) begin
        if (reset) begin
            p_q   <= 0;
            acc_q <= 0;
        end else if (mac_en) begin
            p_q   <= lane_sum(act_sel);
            acc_q <= mac_clr ? 0 : acc_q + weigh(p_q, int'(column_idx), is_msb);
        end
    end

    // Monitor: a handshake at t shows act_sel at t+1 and the column fields at t+2.
    initial begin
        exp_t s1, s2;
        bit f1;
        s1 = bub_e;
        f1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                s1 = bub_e;
                f1 = 1'b0;
            end else begin
                s2 = s1;
                s1 = bub_e;
                if (f1) begin
                    chk("sb_underflow", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) s1 = exp_q.pop_front();
                end
                chk("act_sel", 64'(act_sel), 64'(s1.act));
                chk("col_fields", 64'({hamming_sel, hamming_sign, mul_const, is_shift_mul,
                                       is_skip_zero, column_idx, is_msb}), 64'(s2.fld));
                f1 = desc_valid && desc_ready;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    done_acc = acc_q;
                end
                if (mac_clr) clr_cnt++;
                if (desc_ready) rdy_cnt++;
            end
        end
    end

    task automatic run_tile(input logic [7:0] mask, input int stall_after, input int stall_len,
                            input int poke_after, input int abort_after);
        int cols[$];
        int k = 0, stalled = 0, golden = 0, budget = 0, start_cyc, exp_perf;
        bit aborted = 1'b0, poked = 1'b0;
        exp_t e;
        logic [3:0] junk;
        for (int c = 7; c >= 0; c--) if (mask[c]) cols.push_back(c);
        @(posedge clk); #1;
        done_cnt = 0; clr_cnt = 0; rdy_cnt = 0;
        start = 1'b1; cfg_col_mask = mask; start_cyc = cyc; desc_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_col_mask = ~mask;
        while (done_cnt == 0 && budget < 80 && !aborted) begin
            start = 1'b0;
            if (poke_after >= 0 && k == poke_after && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (stall_after >= 0 && k == stall_after && stalled < stall_len) begin
                desc_valid = 1'b0;
                stalled++;
            end else begin
                desc_valid = 1'b1;
            end
            e = mk_desc(k, 0);
            desc_act_sel = e.act;
            {desc_hamming_sel, desc_hamming_sign, desc_mul_const, desc_shift_mul,
             desc_skip_zero, junk} = e.fld;
            if (abort_after >= 0 && k == abort_after) reset = 1'b1;
            @(negedge clk);
            if (reset) begin
                chk("ready_in_reset", 64'(desc_ready), 64'd0);
                aborted = 1'b1;
            end else if (desc_valid && desc_ready) begin
                if (k >= cols.size()) begin
                    chk("extra_handshake", 64'(k + 1), 64'(cols.size()));
                end else begin
                    e = mk_desc(k, cols[k]);
                    exp_q.push_back(e);
                    golden += weigh(lane_sum(e.act), cols[k], cols[k] == 7);
                end
                k++;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        if (aborted) begin
            reset = 1'b0;
            @(negedge clk);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_ctl", 64'({done, desc_ready, mac_en, mac_clr}), 64'd0);
            repeat (20) @(negedge clk);
            chk("abort_no_done", 64'(done_cnt), 64'd0);
            return;
        end
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
`ifdef MAC_SCHED_PERF_EN
        exp_perf = stalled;
`else
        exp_perf = 0;
`endif
        chk("latency", 64'(done_cyc - start_cyc), 64'(6 + cols.size() + stalled));
        chk("handshakes", 64'(k), 64'(cols.size()));
        chk("ready_cycles", 64'(rdy_cnt), 64'(cols.size() + stalled));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("clr_pulses", 64'(clr_cnt), 64'd1);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("mac_result", 64'(done_acc), 64'(golden));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(exp_perf));
    endtask

    initial begin
        bub_e.act = {LANES{ZS}};
        bub_e.fld = {ZS, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ctl", 64'({done, desc_ready, mac_en, mac_clr}), 64'd0);
        chk("rst_perf", 64'(perf_stall_cnt), 64'd0);
        run_tile(8'hFF, -1, 0, -1, -1);
        run_tile(8'h81, -1, 0, -1, -1);
        run_tile(8'h00, -1, 0, -1, -1);
        run_tile(8'hFF, 2, 3, -1, -1);
        run_tile(8'hFF, -1, 0, -1, 3);
        run_tile(8'hA5, -1, 0, -1, -1);
        run_tile(8'hFF, -1, 0, 4, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
